systolic_nibble_serializer: RTL and testbench
=============================================

Name: systolic_nibble_serializer

Overview:
- Upstream feeder for the systolic tile's row or column port; two instances are used, one per port.
- Accepts one 64-bit block (a 4-vector of BF16) plus 16 per-slot control bits over a valid/ready handshake.
- Emits the block nibble-serially over one 16-cycle frame, aligned to the tile's free-running 0..15 block counter.
- Slot i carries data bits [63-4i:60-4i] and ctrl bit [15-i], MSB nibble first.

Parameters:
- NIB_W, 4, nibble width per cycle.
- NIBBLES, 16, slots per frame; frame length in cycles.
- BLK_W, 64, block width; must equal NIB_W*NIBBLES.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- s_valid  input  1  upstream block valid.
- s_ready  output  1  block accepted on a cycle with s_valid && s_ready.
- s_data  input  64  block payload.
- s_ctrl  input  16  per-slot control bits.
- nib_out  output  4  serial nibble; drives tile ui_in[7:4] or ui_in[3:0].
- ctrl_out  output  1  serial control bit; drives tile uio_in[3] or uio_in[2].
- slot  output  4  current slot index, equal to the tile's count.
- frame_valid  output  1  high for all 16 cycles of a frame carrying a real block.
- frames_sent  output  8  count of real frames launched; wraps at 255->0.

Behaviour:
- Reset (rst_n low at posedge):
  - slot=0, shift/ctrl registers=0, staging empty, frame_valid=0, frames_sent=0.
  - nib_out=0, ctrl_out=0.
  - s_ready is forced 0 while rst_n is low.
  - Reset mid-frame discards the active and staged blocks. Both serializer and tile must share rst_n so the counters stay aligned.
- Counter: slot increments by 1 every cycle, wrapping 15->0.
- Outputs:
  - nib_out = shift_reg[63:60]; ctrl_out = ctrl_reg[15]; all registered.
  - During the cycle with slot==i, the outputs carry slot i of the active block.
  - Each cycle with slot!=15: shift_reg <<= 4 and ctrl_reg <<= 1, with zeros shifted in.
- Staging: one 64+16-bit register with a full flag.
  - s_ready = rst_n && (!stage_full || slot==15).
- Frame boundary (posedge with slot==15), in priority order:
  - If stage_full: load shift/ctrl from staging, frame_valid<=1, frames_sent+1. An accept on this same edge writes the new block into staging, which stays full.
  - Else if accept on this edge: load shift/ctrl directly from s_data/s_ctrl (bypass), frame_valid<=1, frames_sent+1. Staging stays empty.
  - Else: load zeros, giving an idle frame with frame_valid<=0.
- Non-boundary accept (slot!=15, staging empty): write staging; stage_full<=1.
- Latency:
  - Block accepted at slot c<15 with staging empty: first nibble appears at the next slot==0 cycle, i.e. 16-c cycles later.
  - Bypass accept at slot 15: first nibble on the following cycle.
- Throughput: one block per 16 cycles sustained. s_ready is low for slots 0..14 whenever staging is full.
- Back-to-back frames have no gap. An underrun inserts exactly one idle frame, with data and ctrl all zero.

Optional Feature:
- Macro: SYSTOLIC_SERIALIZER_PARITY_EN.
- Defined: the slot-15 ctrl bit is replaced by even parity, i.e. XOR of all 64 data bits and s_ctrl[15:1]. s_ctrl[0] is ignored. Idle frames carry parity 0.
- Undefined: s_ctrl[0] is passed through unchanged in slot 15.

Decomposition:
- Shared package systolic_pkg holds:
  - constants NIB_W, NIBBLES, BLK_W;
  - slot index type (4-bit);
  - block_t struct {data[63:0], ctrl[15:0]};
  - function blk_parity(block_t) returning 1 bit.
- The tile will later import the same constants.
- No sub-module: the staging register and counter are inline.

Test Plan:
- Reset, then hold s_valid=0 for 32 cycles -> nib_out, ctrl_out, frame_valid all 0; slot cycles 0..15 twice; frames_sent=0.
- Assert s_valid at slot 3 with s_data=0x0123456789ABCDEF, s_ctrl=0xA5A5 -> accepted that cycle. At slots 0..15 of the next frame, nib_out = 0,1,...,F and ctrl_out = 1,0,1,0,0,1,0,1,...; frame_valid=1; frames_sent=1.
- Hold s_valid=1 continuously with an incrementing payload -> one accept per frame at slot 15, no idle frames, frames_sent tracks the frame count; s_ready low at slots 0..14 once staging is full.
- Assert s_valid only at slot 15 with staging empty, s_data=0xFFFF000000000000 -> bypass. Next cycle slot=0 and nib_out=F; slots 4..15 give 0.
- Pull rst_n low for 1 cycle at slot 7 mid-frame with a block staged -> next cycle slot=0, outputs 0, staged block lost, frames_sent=0.
- With SYSTOLIC_SERIALIZER_PARITY_EN defined: s_data=0x1, s_ctrl=0x0001 -> ctrl_out at slot 15 = 1 (parity of data), s_ctrl[0] ignored. With the macro undefined -> ctrl_out at slot 15 = 1 from s_ctrl[0]. Repeat with s_ctrl=0x0000: parity build gives 1, non-parity build gives 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Constants, slot/block types and the block parity helper shared by the
// nibble serializer and the systolic tile.
package systolic_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIBBLES = 16;
    localparam int unsigned BLK_W   = NIB_W * NIBBLES;

    typedef logic [3:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NIBBLES - 1);

    typedef struct packed {
        logic [BLK_W-1:0]   data;
        logic [NIBBLES-1:0] ctrl;
    } block_t;

    // Even parity over the payload and every control bit except the slot-15 bit
    // that will carry the result; ctrl is shifted so bit 0 drops out.
    function automatic logic blk_parity(block_t b);
        return (^b.data) ^ (^(b.ctrl >> 1));
    endfunction

endpackage

// File: rtl/systolic_nibble_serializer.sv
// Nibble-serial block feeder aligned to the tile's 0..15 slot counter.
// Optional SYSTOLIC_SERIALIZER_PARITY_EN: slot-15 ctrl bit carries block parity.
module systolic_nibble_serializer #(
    parameter int unsigned NIB_W   = systolic_pkg::NIB_W,
    parameter int unsigned NIBBLES = systolic_pkg::NIBBLES,
    parameter int unsigned BLK_W   = systolic_pkg::BLK_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [BLK_W-1:0]   s_data,
    input  logic [NIBBLES-1:0] s_ctrl,
    output logic [NIB_W-1:0]   nib_out,
    output logic               ctrl_out,
    output logic [3:0]         slot,
    output logic               frame_valid,
    output logic [7:0]         frames_sent
);

`ifdef SYSTOLIC_SERIALIZER_PARITY_EN
    import systolic_pkg::block_t;
    import systolic_pkg::blk_parity;
`endif

    typedef enum logic [1:0] {
        LOAD_IDLE,
        LOAD_STAGE,
        LOAD_BYPASS
    } load_e;

    logic [3:0]         slot_q;
    logic [BLK_W-1:0]   shift_q;
    logic [NIBBLES-1:0] ctrl_q;
    logic [BLK_W-1:0]   stage_data_q;
    logic [NIBBLES-1:0] stage_ctrl_q;
    logic               stage_full_q;
    logic               frame_valid_q;
    logic [7:0]         frames_q;

    logic               boundary;
    logic               accept;
    load_e              load_sel;
    logic [BLK_W-1:0]   load_data;
    logic [NIBBLES-1:0] load_ctrl;
    logic [NIBBLES-1:0] load_ctrl_fin;

    assign boundary = (slot_q == 4'(NIBBLES - 1));
    assign s_ready  = rst_n && (!stage_full_q || boundary);
    assign accept   = s_valid && s_ready;

    // A staged block always launches ahead of a same-edge accept.
    always_comb begin
        load_sel  = LOAD_IDLE;
        load_data = '0;
        load_ctrl = '0;
        if (stage_full_q) begin
            load_sel  = LOAD_STAGE;
            load_data = stage_data_q;
            load_ctrl = stage_ctrl_q;
        end else if (accept) begin
            load_sel  = LOAD_BYPASS;
            load_data = s_data;
            load_ctrl = s_ctrl;
        end
    end

`ifdef SYSTOLIC_SERIALIZER_PARITY_EN
    block_t load_blk;
    assign load_blk = '{data: load_data, ctrl: load_ctrl};
`endif

    always_comb begin
        load_ctrl_fin = load_ctrl;
`ifdef SYSTOLIC_SERIALIZER_PARITY_EN
        load_ctrl_fin[0] = blk_parity(load_blk);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q        <= '0;
            shift_q       <= '0;
            ctrl_q        <= '0;
            stage_data_q  <= '0;
            stage_ctrl_q  <= '0;
            stage_full_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frames_q      <= '0;
        end else begin
            slot_q <= boundary ? '0 : slot_q + 4'd1;
            if (boundary) begin
                shift_q       <= load_data;
                ctrl_q        <= load_ctrl_fin;
                frame_valid_q <= (load_sel != LOAD_IDLE);
                if (load_sel != LOAD_IDLE) begin
                    frames_q <= frames_q + 8'd1;
                end
                // Only a staged launch can refill staging on the same edge;
                // a bypass leaves it empty.
                if (load_sel == LOAD_STAGE) begin
                    stage_full_q <= accept;
                    if (accept) begin
                        stage_data_q <= s_data;
                        stage_ctrl_q <= s_ctrl;
                    end
                end
            end else begin
                shift_q <= shift_q << NIB_W;
                ctrl_q  <= ctrl_q << 1;
                if (accept) begin
                    stage_data_q <= s_data;
                    stage_ctrl_q <= s_ctrl;
                    stage_full_q <= 1'b1;
                end
            end
        end
    end

    assign nib_out     = shift_q[BLK_W-1 -: NIB_W];
    assign ctrl_out    = ctrl_q[NIBBLES-1];
    assign slot        = slot_q;
    assign frame_valid = frame_valid_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_systolic_nibble_serializer.sv
// Self-checking bench for systolic_nibble_serializer: transaction-level model
// plus directed literal checks; honours SYSTOLIC_SERIALIZER_PARITY_EN.
module tb_systolic_nibble_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic [15:0] s_ctrl = '0;
    logic [3:0]  nib_out;
    logic        ctrl_out;
    logic [3:0]  slot;
    logic        frame_valid;
    logic [7:0]  frames_sent;

    systolic_nibble_serializer #(
        .NIB_W   (4),
        .NIBBLES (16),
        .BLK_W   (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_ctrl      (s_ctrl),
        .nib_out     (nib_out),
        .ctrl_out    (ctrl_out),
        .slot        (slot),
        .frame_valid (frame_valid),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: blocks accepted but not yet launched, and the block on the wire.
    logic [79:0] pending[$];
    logic [63:0] cur_data = '0;
    logic [15:0] cur_ctrl = '0;
    bit          cur_valid = 0;
    logic [7:0]  m_frames = '0;
    int          m_slot = 0;
    bit          armed = 0;
    bit          last_acc = 0;

    function automatic bit model_ready();
        return rst_n && (pending.size() == 0 || m_slot == 15);
    endfunction

    function automatic logic exp_ctrl(int k);
`ifdef SYSTOLIC_SERIALIZER_PARITY_EN
        if (k == 15) return (^cur_data) ^ (^cur_ctrl[15:1]);
`endif
        return cur_ctrl[15-k];
    endfunction

    initial forever begin
        @(posedge clk);
        last_acc = 0;
        if (!rst_n) begin
            armed = 1;
            pending.delete();
            cur_data = '0; cur_ctrl = '0; cur_valid = 0;
            m_frames = '0; m_slot = 0;
        end else begin
            last_acc = s_valid && model_ready();
            if (last_acc) pending.push_back({s_data, s_ctrl});
            if (m_slot == 15) begin
                m_slot = 0;
                if (pending.size() > 0) begin
                    {cur_data, cur_ctrl} = pending.pop_front();
                    cur_valid = 1;
                    m_frames = m_frames + 8'd1;
                end else begin
                    cur_data = '0; cur_ctrl = '0; cur_valid = 0;
                end
            end else begin
                m_slot = m_slot + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("slot", slot, 64'(m_slot));
            chk("nib_out", nib_out, 64'(cur_data[63-4*m_slot -: 4]));
            chk("ctrl_out", ctrl_out, 64'(exp_ctrl(m_slot)));
            chk("frame_valid", frame_valid, 64'(cur_valid));
            chk("frames_sent", frames_sent, 64'(m_frames));
            chk("s_ready", s_ready, 64'(model_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input int target);
        int n = 0;
        while (m_slot != target && n < 64) begin
            tick();
            n++;
        end
        if (m_slot != target) begin
            checks++;
            errors++;
            $display("FAIL wait_slot: got slot %0d expected %0d", m_slot, target);
        end
    endtask

    logic [63:0] cap_n;
    logic [15:0] cap_c;

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Idle after reset: two all-zero frames.
        repeat (32) tick();
        chk("idle_frames_sent", frames_sent, 0);

        // Staged accept at slot 3, launched at the next frame.
        wait_slot(3);
        s_valid = 1'b1; s_data = 64'h0123456789ABCDEF; s_ctrl = 16'hA5A5;
        @(negedge clk);
        chk("dir_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        wait_slot(0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            cap_n = {cap_n[59:0], nib_out};
            cap_c = {cap_c[14:0], ctrl_out};
            if (k == 0) chk("dir_frames_sent", frames_sent, 1);
            if (k == 15) chk("dir_frame_valid", frame_valid, 1);
            tick();
        end
        chk("dir_nibbles", cap_n, 64'h0123456789ABCDEF);
        chk("dir_ctrl", cap_c, 16'hA5A5);

        // Continuous stream long enough to wrap frames_sent.
        s_valid = 1'b1; s_data = 64'h1000; s_ctrl = 16'h0001;
        for (int i = 0; i < 270 * 16; i++) begin
            tick();
            if (last_acc) begin
                s_data = s_data + 64'd1;
                s_ctrl = s_ctrl + 16'd1;
            end
        end
        wait_slot(5);
        @(negedge clk);
        chk("stream_ready_low", s_ready, 0);
        tick();
        s_valid = 1'b0;
        repeat (40) tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            s_valid = ($urandom_range(2) == 0);
            s_data  = {$urandom, $urandom};
            s_ctrl  = 16'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (40) tick();

        // Bypass at slot 15.
        wait_slot(15);
        s_valid = 1'b1; s_data = 64'hFFFF000000000000; s_ctrl = 16'h8000;
        @(negedge clk);
        chk("byp_ready", s_ready, 1);
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        chk("byp_slot0", slot, 0);
        chk("byp_nib0", nib_out, 4'hF);
        repeat (4) tick();
        @(negedge clk);
        chk("byp_slot4", slot, 4);
        chk("byp_nib4", nib_out, 0);
        repeat (30) tick();

        // Reset mid-frame with a block staged.
        wait_slot(2);
        s_valid = 1'b1; s_data = {$urandom, $urandom}; s_ctrl = 16'hFFFF;
        tick();
        s_valid = 1'b0;
        wait_slot(7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", s_ready, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_slot", slot, 0);
        chk("rst_nib", nib_out, 0);
        chk("rst_frames", frames_sent, 0);
        chk("rst_fv", frame_valid, 0);
        repeat (40) tick();
        chk("rst_lost", frames_sent, 0);

        // Slot-15 control bit: parity versus passthrough.
        for (int t = 0; t < 2; t++) begin
            wait_slot(15);
            s_valid = 1'b1; s_data = 64'h1; s_ctrl = (t == 0) ? 16'h0001 : 16'h0000;
            tick();
            s_valid = 1'b0;
            wait_slot(15);
            @(negedge clk);
`ifdef SYSTOLIC_SERIALIZER_PARITY_EN
            chk("par_slot15", ctrl_out, 1);
`else
            chk("par_slot15", ctrl_out, (t == 0) ? 1 : 0);
`endif
            tick();
        end

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
